inst_fetch_unit: RTL and testbench
==================================

# inst_fetch_unit

Instruction fetch stage directly upstream of the instruction cache. It holds the PC and presents it to the cache for a combinational lookup. On a hit it delivers the instruction to decode through a one-entry valid/ready slot. On a miss it reads the 4-byte word over the byte-wide memory bus, writes it into the cache, and retries the lookup.

## Interface
- RESET_PC, 32'h0, PC loaded at reset

- clk_in  in  1  system clock
- rst_in  in  1  reset; asynchronous, active-low
- rdy_in  in  1  global ready; low freezes all state
- cache_addr  out  32  lookup/update address (= pc)
- cache_hit  in  1  combinational hit for cache_addr, same cycle
- cache_data  in  32  combinational hit data
- cache_update  out  1  one-cycle write strobe to cache
- cache_update_data  out  32  word written (address = cache_addr)
- mem_req  out  1  byte read request
- mem_a  out  32  byte address
- mem_gnt  in  1  arbiter accepted mem_a this cycle
- mem_din  in  8  byte for the address granted in the previous cycle
- inst_valid  out  1  instruction slot full
- inst  out  32  instruction
- inst_pc  out  32  its PC
- inst_ready  in  1  decode consumes slot this cycle
- flush  in  1  redirect
- flush_pc  in  32  new PC

## Operation
- Registers: pc, state {LOOKUP, FILL, WRITE}, issue_cnt[2:0], recv_cnt[2:0], inflight (a granted byte is due next cycle), inflight_idx[1:0], word[31:0], output slot {inst_valid, inst, inst_pc}.
- Reset (rst_in low, async): pc=RESET_PC, state=LOOKUP, counters=0, inflight=0, inst_valid=0, inst=0, inst_pc=0, cache_update=0, mem_req=0, mem_a=0.
- slot_free = !inst_valid || inst_ready.
- LOOKUP: cache_addr=pc.
  - cache_hit && slot_free: load slot {cache_data, pc}; pc+=4 (wraps mod 2^32).
  - !cache_hit: go to FILL with issue_cnt=recv_cnt=0. This happens whether or not the slot is free.
  - cache_hit && !slot_free: hold.
- FILL:
  - mem_req = (issue_cnt<4); mem_a = pc + issue_cnt.
  - mem_gnt && mem_req: issue_cnt++; inflight=1 next cycle with inflight_idx=issue_cnt.
  - When inflight is set, mem_din goes to word[8*inflight_idx +: 8] (little-endian) and recv_cnt increments.
  - recv_cnt reaching 4 goes to WRITE.
- WRITE: one cycle with cache_update=1, cache_update_data=word, cache_addr=pc. Then LOOKUP, which hits.
- The slot drains independently: inst_ready with inst_valid clears the slot unless the slot is reloaded the same cycle.
- Flush has priority over everything except the WRITE strobe:
  - pc=flush_pc, inst_valid=0, state=LOOKUP, counters=0.
  - inflight is squashed, so next cycle's mem_din is ignored.
  - A WRITE-cycle cache_update still commits (old pc, valid data).
  - A hit in the flush cycle is not loaded.
- rdy_in low: no register changes, mem_req=0, cache_update=0. Memory is paused by the same signal, so no byte is lost.
- cache_update and mem_req are never high together.

## Timing
- Hit: pc presented cycle t → inst_valid at t+1. Sustains one instruction per cycle while inst_ready=1.
- Miss with continuous grant, miss seen in cycle t:
  - grants t+1..t+4
  - bytes t+2..t+5
  - WRITE t+6
  - LOOKUP hit t+7
  - inst_valid t+8
- Each grant-low cycle adds one cycle. mem_a holds while ungranted.
- The flush cycle's effects are visible the next cycle. The lookup of flush_pc occurs in cycle t+1.

## Test plan
- Reset: hold rst_in low mid-FILL, release → inst_valid=0, mem_req=0; first cache_addr=RESET_PC=0.
- Hit stream: cache always hits with data=addr^32'hA5A5A5A5, inst_ready=1 → one instruction per cycle, inst_pc 0,4,8,12, inst correct.
- Miss fill: cache misses at pc=0x100, mem_gnt=1, bytes 0x13,0x05,0x10,0x00 → mem_a 0x100..0x103; cache_update=1 with data 0x00100513 at cycle t+6; inst_valid at t+8 with inst=0x00100513.
- Grant stalls: the same miss with mem_gnt low on alternate cycles → mem_a holds while ungranted; the assembled word is identical; each stall adds one cycle.
- Flush mid-fill: flush_pc=0x200 asserted after 2 bytes → the third byte is ignored, no cache_update, next cache_addr=0x200, inst_valid stays 0.
- Backpressure/wrap: pc=0xFFFFFFFC hit, inst_ready=0 for 3 cycles → inst and inst_pc stable, pc holds. After release the next pc is 0x00000000.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: holds the PC, looks it up in the instruction cache, and hands
// hits to decode through a one-entry slot. A miss fetches the word a byte at a time and refills the cache.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic [31:0] cache_addr,
    input  logic        cache_hit,
    input  logic [31:0] cache_data,
    output logic        cache_update,
    output logic [31:0] cache_update_data,
    output logic        mem_req,
    output logic [31:0] mem_a,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_din,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        flush,
    input  logic [31:0] flush_pc
);

    typedef enum logic [1:0] {
        S_LOOKUP = 2'd0,
        S_FILL   = 2'd1,
        S_WRITE  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [2:0]  r_issue_cnt;
    logic [2:0]  r_recv_cnt;
    logic        r_inflight;
    logic [1:0]  r_inflight_idx;
    logic [31:0] r_word;
    logic        r_inst_valid;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;

    logic w_slot_free;
    logic w_mem_req;
    logic w_issue;

    assign w_slot_free = !r_inst_valid || inst_ready;
    assign w_mem_req   = rdy_in && (r_state == S_FILL) && (r_issue_cnt < 3'd4);
    assign w_issue     = w_mem_req && mem_gnt;

    assign cache_addr        = r_pc;
    assign cache_update      = rdy_in && (r_state == S_WRITE);
    assign cache_update_data = r_word;
    assign mem_req           = w_mem_req;
    assign mem_a             = r_pc + {29'd0, r_issue_cnt};
    assign inst_valid        = r_inst_valid;
    assign inst              = r_inst;
    assign inst_pc           = r_inst_pc;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state        <= S_LOOKUP;
            r_pc           <= RESET_PC;
            r_issue_cnt    <= 3'd0;
            r_recv_cnt     <= 3'd0;
            r_inflight     <= 1'b0;
            r_inflight_idx <= 2'd0;
            r_word         <= 32'd0;
            r_inst_valid   <= 1'b0;
            r_inst         <= 32'd0;
            r_inst_pc      <= 32'd0;
        end else if (rdy_in) begin
            if (flush) begin
                // The WRITE strobe is combinational, so it still commits in this cycle.
                r_state     <= S_LOOKUP;
                r_pc        <= flush_pc;
                r_issue_cnt <= 3'd0;
                r_recv_cnt  <= 3'd0;
                r_inflight  <= 1'b0;
                r_inst_valid <= 1'b0;
            end else begin
                if (r_inst_valid && inst_ready)
                    r_inst_valid <= 1'b0;

                case (r_state)
                    S_LOOKUP: begin
                        if (cache_hit) begin
                            if (w_slot_free) begin
                                r_inst_valid <= 1'b1;
                                r_inst       <= cache_data;
                                r_inst_pc    <= r_pc;
                                r_pc         <= r_pc + 32'd4;
                            end
                        end else begin
                            r_state     <= S_FILL;
                            r_issue_cnt <= 3'd0;
                            r_recv_cnt  <= 3'd0;
                            r_inflight  <= 1'b0;
                        end
                    end
                    S_FILL: begin
                        r_inflight <= w_issue;
                        if (w_issue) begin
                            r_issue_cnt    <= r_issue_cnt + 3'd1;
                            r_inflight_idx <= r_issue_cnt[1:0];
                        end
                        // Byte granted last cycle lands little-endian in the word.
                        if (r_inflight) begin
                            r_word[{r_inflight_idx, 3'b000} +: 8] <= mem_din;
                            r_recv_cnt <= r_recv_cnt + 3'd1;
                            if (r_recv_cnt == 3'd3)
                                r_state <= S_WRITE;
                        end
                    end
                    S_WRITE: begin
                        r_state <= S_LOOKUP;
                    end
                    default: begin
                        r_state <= S_LOOKUP;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a small cache model (one missing address that refills)
// and a byte-wide memory returning the bytes of 32'h00100513.
module tb_inst_fetch_unit;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] cache_addr;
    logic        cache_hit;
    logic [31:0] cache_data;
    logic        cache_update;
    logic [31:0] cache_update_data;
    logic        mem_req;
    logic [31:0] mem_a;
    logic        mem_gnt;
    logic [7:0]  mem_din;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        flush;
    logic [31:0] flush_pc;

    logic        miss_en;
    logic [31:0] miss_addr;
    logic        clr_filled;
    logic        filled;
    logic [31:0] fill_data;

    int checks = 0;
    int errors = 0;

    inst_fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .cache_addr        (cache_addr),
        .cache_hit         (cache_hit),
        .cache_data        (cache_data),
        .cache_update      (cache_update),
        .cache_update_data (cache_update_data),
        .mem_req           (mem_req),
        .mem_a             (mem_a),
        .mem_gnt           (mem_gnt),
        .mem_din           (mem_din),
        .inst_valid        (inst_valid),
        .inst              (inst),
        .inst_pc           (inst_pc),
        .inst_ready        (inst_ready),
        .flush             (flush),
        .flush_pc          (flush_pc)
    );

    always #5 clk_in = ~clk_in;

    // Cache model: every address hits with addr^A5A5A5A5 except miss_addr until it is refilled.
    always_comb begin
        cache_hit  = 1'b1;
        cache_data = cache_addr ^ 32'hA5A5A5A5;
        if (miss_en && (cache_addr == miss_addr)) begin
            cache_hit  = filled;
            cache_data = fill_data;
        end
    end

    always @(posedge clk_in) begin
        if (clr_filled) begin
            filled    <= 1'b0;
            fill_data <= 32'd0;
        end else if (cache_update && (cache_addr == miss_addr)) begin
            filled    <= 1'b1;
            fill_data <= cache_update_data;
        end
    end

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        logic [31:0] w;
        w = 32'h00100513;
        return w[{a[1:0], 3'b000} +: 8];
    endfunction

    always @(posedge clk_in) begin
        if (rdy_in)
            mem_din <= (mem_req && mem_gnt) ? byte_at(mem_a) : 8'hEE;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_miss_at_100();
        clr_filled = 1'b1;
        flush      = 1'b1;
        flush_pc   = 32'h100;
        tick();
        clr_filled = 1'b0;
        flush      = 1'b0;
    endtask

    initial begin
        rst_in     = 1'b0;
        rdy_in     = 1'b1;
        inst_ready = 1'b1;
        flush      = 1'b0;
        flush_pc   = 32'd0;
        mem_gnt    = 1'b1;
        miss_en    = 1'b0;
        miss_addr  = 32'h100;
        clr_filled = 1'b1;

        // Reset state
        tick();
        $display("reset: checking idle outputs");
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_cache_update", {31'd0, cache_update}, 32'd0);
        check("rst_cache_addr", cache_addr, 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_inst", inst, 32'd0);
        rst_in     = 1'b1;
        clr_filled = 1'b0;

        // Hit stream
        for (int k = 0; k < 4; k++) begin
            tick();
            $display("hit: inst_pc=%h inst=%h", inst_pc, inst);
            check("hit_valid", {31'd0, inst_valid}, 32'd1);
            check("hit_pc", inst_pc, 32'(4 * k));
            check("hit_inst", inst, 32'(4 * k) ^ 32'hA5A5A5A5);
        end

        // Miss fill with continuous grant
        miss_en = 1'b1;
        start_miss_at_100();
        $display("miss: lookup at %h", cache_addr);
        check("miss_cache_addr", cache_addr, 32'h100);
        check("miss_flush_no_load", {31'd0, inst_valid}, 32'd0);
        check("miss_lookup_no_req", {31'd0, mem_req}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            $display("miss: req mem_a=%h", mem_a);
            check("miss_req", {31'd0, mem_req}, 32'd1);
            check("miss_mem_a", mem_a, 32'h100 + 32'(i - 1));
        end
        tick();
        check("miss_req_done", {31'd0, mem_req}, 32'd0);
        check("miss_no_early_update", {31'd0, cache_update}, 32'd0);
        tick();
        $display("miss: update data=%h", cache_update_data);
        check("miss_update", {31'd0, cache_update}, 32'd1);
        check("miss_update_data", cache_update_data, 32'h00100513);
        check("miss_update_addr", cache_addr, 32'h100);
        check("miss_update_no_req", {31'd0, mem_req}, 32'd0);
        tick();
        check("miss_update_once", {31'd0, cache_update}, 32'd0);
        check("miss_t7_empty", {31'd0, inst_valid}, 32'd0);
        tick();
        $display("miss: inst_pc=%h inst=%h", inst_pc, inst);
        check("miss_valid", {31'd0, inst_valid}, 32'd1);
        check("miss_inst", inst, 32'h00100513);
        check("miss_inst_pc", inst_pc, 32'h100);

        // Same miss with grant low on alternate cycles
        start_miss_at_100();
        for (int i = 1; i <= 8; i++) begin
            tick();
            mem_gnt = (i % 2 == 0);
            $display("stall: mem_a=%h gnt=%0d", mem_a, mem_gnt);
            check("stall_req", {31'd0, mem_req}, 32'd1);
            check("stall_mem_a", mem_a, 32'h100 + 32'((i - 1) / 2));
        end
        tick();
        check("stall_req_done", {31'd0, mem_req}, 32'd0);
        check("stall_no_early_update", {31'd0, cache_update}, 32'd0);
        tick();
        $display("stall: update data=%h", cache_update_data);
        check("stall_update", {31'd0, cache_update}, 32'd1);
        check("stall_update_data", cache_update_data, 32'h00100513);
        tick();
        tick();
        check("stall_valid", {31'd0, inst_valid}, 32'd1);
        check("stall_inst", inst, 32'h00100513);

        // Flush after two bytes of a fill
        start_miss_at_100();
        tick();
        tick();
        tick();
        check("fl_mem_a", mem_a, 32'h102);
        flush    = 1'b1;
        flush_pc = 32'h200;
        tick();
        flush = 1'b0;
        $display("flush: lookup at %h", cache_addr);
        check("fl_cache_addr", cache_addr, 32'h200);
        check("fl_valid", {31'd0, inst_valid}, 32'd0);
        check("fl_req", {31'd0, mem_req}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("fl_no_update", {31'd0, cache_update}, 32'd0);
            tick();
            if (i == 0)
                check("fl_first_pc", inst_pc, 32'h200);
        end

        // Reset asserted in the middle of a fill
        start_miss_at_100();
        tick();
        tick();
        rst_in = 1'b0;
        #1;
        $display("reset mid-fill");
        check("rstf_valid", {31'd0, inst_valid}, 32'd0);
        check("rstf_req", {31'd0, mem_req}, 32'd0);
        check("rstf_cache_addr", cache_addr, 32'd0);
        tick();
        rst_in = 1'b1;
        tick();
        check("rstf_first_valid", {31'd0, inst_valid}, 32'd1);
        check("rstf_first_pc", inst_pc, 32'd0);

        // Backpressure at the top of the address space, then wrap
        inst_ready = 1'b0;
        flush      = 1'b1;
        flush_pc   = 32'hFFFFFFFC;
        tick();
        flush = 1'b0;
        check("bp_cache_addr", cache_addr, 32'hFFFFFFFC);
        for (int j = 1; j <= 3; j++) begin
            tick();
            $display("backpressure: inst_pc=%h inst=%h", inst_pc, inst);
            check("bp_valid", {31'd0, inst_valid}, 32'd1);
            check("bp_inst_pc", inst_pc, 32'hFFFFFFFC);
            check("bp_inst", inst, 32'h5A5A5A59);
            check("bp_pc_hold", cache_addr, 32'd0);
        end
        inst_ready = 1'b1;
        tick();
        $display("wrap: inst_pc=%h inst=%h", inst_pc, inst);
        check("wrap_inst_pc", inst_pc, 32'd0);
        check("wrap_inst", inst, 32'hA5A5A5A5);
        check("wrap_cache_addr", cache_addr, 32'd4);

        // Global ready low freezes everything
        rdy_in = 1'b0;
        tick();
        check("rdy_hold_pc", inst_pc, 32'd0);
        check("rdy_hold_addr", cache_addr, 32'd4);
        check("rdy_no_req", {31'd0, mem_req}, 32'd0);
        rdy_in = 1'b1;
        tick();
        $display("ready resumed: inst_pc=%h", inst_pc);
        check("rdy_resume_pc", inst_pc, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
